// File: rtl/max1112x_pkg.sv
// Shared constants and state type for the MAX1112x ADC responder.
// Frame layout: 4-bit channel ID + 12-bit conversion word, MSB first.
package max1112x_pkg;

    localparam int FRAME_W   = 16;
    localparam int CNT_W     = 5;
    localparam int CHSEL_MSB = 10;
    localparam int CHSEL_LSB = 7;
    localparam int REG_BIT   = 15;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

endpackage

// File: rtl/max1112x_responder_spi_sync_edge.sv
// Two-flop synchroniser for one SPI pin with registered edge pulses.
// Resets to 0 so a chip select already low at reset release never looks like a fall.
module spi_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic s1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= 1'b0;
            dout <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= din;
            dout <= s1;
            rise <= s1 & ~dout;
            fall <= ~s1 & dout;
        end
    end

endmodule

// File: rtl/max1112x_responder.sv
// SPI slave emulating the MAX1112x ADC for benches and ADC-less builds.
// Define MAX1112X_RESPONDER_SCAN_EN to auto-advance the channel after each mode command.
module max1112x_responder
    import max1112x_pkg::*;
#(
    parameter int C_channels = 4,
    parameter int C_bits     = 12
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         spi_csn,
    input  logic                         spi_clk,
    input  logic                         spi_mosi,
    output logic                         spi_miso,
    input  logic [C_channels*C_bits-1:0] ch_value,
    output logic [FRAME_W-1:0]           cmd,
    output logic                         cmd_valid,
    output logic [FRAME_W-1:0]           cfg,
    output logic [7:0]                   abort_count
);

    logic csn_s, csn_rise, csn_fall;
    logic clk_s, clk_rise, clk_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync_edge u_sync_csn (
        .clk   (clk),
        .reset (reset),
        .din   (spi_csn),
        .dout  (csn_s),
        .rise  (csn_rise),
        .fall  (csn_fall)
    );

    spi_sync_edge u_sync_clk (
        .clk   (clk),
        .reset (reset),
        .din   (spi_clk),
        .dout  (clk_s),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    spi_sync_edge u_sync_mosi (
        .clk   (clk),
        .reset (reset),
        .din   (spi_mosi),
        .dout  (mosi_s),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{csn_s, clk_s, mosi_rise, mosi_fall};

    state_t state_q, state_d;

    logic [CNT_W-1:0]   bit_cnt, cnt_next;
    logic [FRAME_W-1:0] rx, rx_next;
    logic [FRAME_W-1:0] tx;
    logic [3:0]         cur_ch;
    logic [C_bits-1:0]  slot_val;
    logic               done;
    logic               shifting;
    logic               take;

    assign spi_miso = tx[FRAME_W-1];
    assign shifting = (state_q == SHIFT);
    assign take     = shifting && clk_rise && (bit_cnt < 5'd16);
    assign cnt_next = take ? bit_cnt + 5'd1 : bit_cnt;
    assign rx_next  = take ? {rx[FRAME_W-2:0], mosi_s} : rx;

    // Channels beyond C_channels match no slot and read as zero
    always_comb begin
        slot_val = '0;
        for (int n = 0; n < C_channels; n++) begin
            if (cur_ch == 4'(n)) begin
                slot_val = ch_value[n*C_bits +: C_bits];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (csn_fall) state_d = SHIFT;
            SHIFT:   state_d = SHIFT;
            default: state_d = IDLE;
        endcase
        if (csn_rise) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt     <= '0;
            rx          <= '0;
            tx          <= '0;
            cur_ch      <= '0;
            done        <= 1'b0;
            cmd         <= '0;
            cmd_valid   <= 1'b0;
            cfg         <= '0;
            abort_count <= '0;
        end else begin
            cmd_valid <= 1'b0;
            done      <= 1'b0;
            if (state_q == IDLE && csn_fall) begin
                bit_cnt <= '0;
                tx      <= {cur_ch, slot_val};
            end else if (shifting) begin
                // A rise coinciding with csn rise is still shifted in
                bit_cnt <= cnt_next;
                rx      <= rx_next;
                if (take && bit_cnt == 5'd15) begin
                    done <= 1'b1;
                end
                if (clk_fall) begin
                    tx <= {tx[FRAME_W-2:0], 1'b0};
                end
                if (csn_rise && cnt_next != '0 && cnt_next < 5'd16
                    && abort_count != 8'hFF) begin
                    abort_count <= abort_count + 8'd1;
                end
            end
            if (done) begin
                cmd       <= rx;
                cmd_valid <= 1'b1;
                if (rx[REG_BIT]) begin
                    cfg <= rx;
                end else begin
`ifdef MAX1112X_RESPONDER_SCAN_EN
                    cur_ch <= (cur_ch == 4'(C_channels-1)) ? 4'd0 : cur_ch + 4'd1;
`else
                    cur_ch <= rx[CHSEL_MSB:CHSEL_LSB];
`endif
                end
            end
        end
    end

endmodule
